// File: rtl/rgb_pwm_scheduler_pkg.sv
// Shared types and helpers for the RGB PWM scheduler: FSM state encoding and duty clamping.
package pwm_sched_pkg;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } sched_state_t;

    // Saturate a requested on-time to the period length, so over-range requests mean "always on".
    function automatic int unsigned clamp_duty(input int unsigned value, input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: active/shadow duty registers with clamp-on-capture and a registered compare
// against the shared period counter, optionally shifted by a fixed phase offset.
module pwm_channel_cmp
    import pwm_sched_pkg::*;
#(
    parameter  int PWM_INTERVAL = 1200,
    parameter  int PHASE        = 0,
    localparam int W            = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pcnt,
    input  logic         live,
    input  logic         load_active,
    input  logic         load_shadow,
    input  logic         promote,
    input  logic [W-1:0] duty,
    output logic         pwm
);
    localparam logic [W:0] PERIOD = (W + 1)'(PWM_INTERVAL);
    localparam logic [W:0] OFFSET = (W + 1)'(PHASE);

    logic [W-1:0] active;
    logic [W-1:0] shadow;
    logic [W-1:0] captured;
    logic [W:0]   pos;

    assign captured = W'(clamp_duty(32'(duty), PWM_INTERVAL));

    // NOTE: every branch of a combinational block must assign its outputs, or a latch is inferred.
    always_comb begin
        pos = {1'b0, pcnt};
        if ({1'b0, pcnt} < OFFSET) begin
            pos = {1'b0, pcnt} + PERIOD - OFFSET;
        end else begin
            pos = {1'b0, pcnt} - OFFSET;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
            shadow <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load_active) begin
                active <= captured;
            end else if (promote) begin
                active <= shadow;
            end
            if (load_shadow) begin
                shadow <= captured;
            end
            pwm <= live && (pos < {1'b0, active});
        end
    end

endmodule

// File: rtl/rgb_pwm_scheduler.sv
// Shared PWM time base for red/green/blue, with period-boundary duty swaps and the fade step strobe.
// Define PWM_STAGGER_EN to phase-stagger green and blue turn-on by one and two thirds of a period.
module rgb_pwm_scheduler
    import pwm_sched_pkg::*;
#(
    parameter  int PWM_INTERVAL  = 1200,
    parameter  int STEP_INTERVAL = 20000,
    localparam int W             = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         duty_valid,
    output logic         duty_ready,
    input  logic [W-1:0] red_duty,
    input  logic [W-1:0] green_duty,
    input  logic [W-1:0] blue_duty,
    output logic         step_tick,
    output logic         period_start,
    output logic         red_out,
    output logic         green_out,
    output logic         blue_out
);
    localparam int SW = $clog2(STEP_INTERVAL);

`ifdef PWM_STAGGER_EN
    localparam int GREEN_PHASE = PWM_INTERVAL / 3;
    localparam int BLUE_PHASE  = 2 * PWM_INTERVAL / 3;
`else
    localparam int GREEN_PHASE = 0;
    localparam int BLUE_PHASE  = 0;
`endif

    localparam logic [W-1:0]  PCNT_LAST = W'(PWM_INTERVAL - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(STEP_INTERVAL - 1);

    sched_state_t  state_q;
    sched_state_t  state_d;
    logic [W-1:0]  pcnt;
    logic [SW-1:0] scnt;
    logic          pending;
    logic          running;
    logic          live;
    logic          wrap;
    logic          boundary;
    logic          xfer;
    logic          load_active;
    logic          load_shadow;
    logic          promote;

    // NOTE: every flop, including the duty registers, is cleared by rst so a pending shadow value is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = OFF;
            default: state_d = OFF;
        endcase
    end

    assign running  = (state_q == RUN);
    assign live     = running && enable;
    assign wrap     = running && (pcnt == PCNT_LAST);
    // While off every cycle behaves like a period boundary: writes go straight to the active set.
    assign boundary = !running || wrap;

    assign duty_ready  = !running || !pending;
    assign xfer        = duty_valid && duty_ready;
    assign load_active = xfer && boundary;
    assign load_shadow = xfer && !boundary;
    assign promote     = pending && boundary;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            scnt <= '0;
        end else if (live) begin
            pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
            scnt <= (scnt == SCNT_LAST) ? '0 : scnt + 1'b1;
        end else begin
            pcnt <= '0;
            scnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (load_shadow) begin
            pending <= 1'b1;
        end else if (boundary) begin
            pending <= 1'b0;
        end
    end

    assign step_tick    = running && (scnt == SCNT_LAST);
    assign period_start = running && (pcnt == '0);

    pwm_channel_cmp #(.PWM_INTERVAL(PWM_INTERVAL), .PHASE(0)) u_red (
        .clk         (clk),
        .rst         (rst),
        .pcnt        (pcnt),
        .live        (live),
        .load_active (load_active),
        .load_shadow (load_shadow),
        .promote     (promote),
        .duty        (red_duty),
        .pwm         (red_out)
    );

    pwm_channel_cmp #(.PWM_INTERVAL(PWM_INTERVAL), .PHASE(GREEN_PHASE)) u_green (
        .clk         (clk),
        .rst         (rst),
        .pcnt        (pcnt),
        .live        (live),
        .load_active (load_active),
        .load_shadow (load_shadow),
        .promote     (promote),
        .duty        (green_duty),
        .pwm         (green_out)
    );

    pwm_channel_cmp #(.PWM_INTERVAL(PWM_INTERVAL), .PHASE(BLUE_PHASE)) u_blue (
        .clk         (clk),
        .rst         (rst),
        .pcnt        (pcnt),
        .live        (live),
        .load_active (load_active),
        .load_shadow (load_shadow),
        .promote     (promote),
        .duty        (blue_duty),
        .pwm         (blue_out)
    );

endmodule

// File: doc/rgb_pwm_scheduler.md
# rgb_pwm_scheduler

Owns the PWM time base shared by the red, green and blue channels. It double-buffers duty values from the colour-fade datapath and swaps them in only at a period boundary, so no channel sees a torn period. It also generates the single-cycle step strobe that paces the fade datapath, all in the `clk` domain with no derived clocks. It sits between the fade datapath (upstream) and the LED pins (downstream).

## Interface
- `PWM_INTERVAL`, 1200: PWM period in `clk` cycles (100 us at 12 MHz).
- `STEP_INTERVAL`, 20000: cycles between `step_tick` pulses.
- `W`, `$clog2(PWM_INTERVAL)`: duty width (derived, not overridden).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, 12 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  high runs PWM; low forces outputs off.
- `duty_valid`  in  1  upstream has a new duty triple.
- `duty_ready`  out  1  scheduler can accept a triple.
- `red_duty`, `green_duty`, `blue_duty`  in  W  requested on-cycles per period.
- `step_tick`  out  1  one-cycle strobe every `STEP_INTERVAL` cycles while running.
- `period_start`  out  1  one-cycle strobe on the first cycle of each PWM period.
- `red_out`, `green_out`, `blue_out`  out  1  PWM pin drives, registered.

## Operation
- State machine with two states:
  - OFF: `enable` low. Period counter and step counter are held at 0. `step_tick`, `period_start` and all `*_out` are 0.
  - RUN: `enable` high.
  - Transitions: OFF→RUN on `enable`=1. RUN→OFF on `enable`=0. The counters restart from 0 on every OFF→RUN transition.
- Period counter `pcnt` counts 0..`PWM_INTERVAL`-1 and then wraps to 0.
- Step counter `scnt` counts 0..`STEP_INTERVAL`-1. `step_tick`=1 in the cycle where `scnt`==`STEP_INTERVAL`-1.
- Duty values are clamped on capture: any value above `PWM_INTERVAL` is stored as `PWM_INTERVAL`.
- Handshake: a transfer occurs when `duty_valid`&&`duty_ready`.
  - In OFF: the captured triple loads directly into the active registers, and `duty_ready` stays 1.
  - In RUN: the triple loads into shadow registers and sets `pending`. `duty_ready`=!`pending`.
  - At each wrap (`pcnt`==`PWM_INTERVAL`-1 → 0), shadow→active and `pending` clears.
  - A transfer in the same cycle as a wrap goes straight to active, and `pending` stays 0.
  - Upstream holds data stable while `duty_valid` is high and not accepted.
- Compare: a channel is on when `pcnt` < active duty. Duty 0 means always low; duty `PWM_INTERVAL` means always high.
- `period_start`=1 while `pcnt`==0 in RUN.
- Reset values: `duty_ready`=1. `step_tick`, `period_start` and all `*_out`=0. Active, shadow, `pending`, `pcnt` and `scnt` are all 0. State is OFF.
- Reset mid-period: outputs drop asynchronously, and any pending shadow value is discarded.

## Timing
- `*_out` is registered: it reflects the compare of `pcnt` from the previous cycle. The high pulse is exactly duty cycles wide.
- The first `period_start` occurs one cycle after `enable` is sampled high.
- Accepted-to-effective latency is at most one period. The new duty applies from `pcnt`==0 of the next period, and appears on `*_out` one cycle later.
- The first `step_tick` occurs `STEP_INTERVAL` cycles after entering RUN, with a period of exactly `STEP_INTERVAL`.
- `enable` falling: all `*_out` are 0 on the next cycle.

## Configuration
- `PWM_STAGGER_EN` defined: channel turn-on is phase-staggered to cut simultaneous switching current.
  - Green compares (`pcnt` − `PWM_INTERVAL`/3) mod `PWM_INTERVAL`.
  - Blue compares (`pcnt` − 2·`PWM_INTERVAL`/3) mod `PWM_INTERVAL`.
  - Red is unshifted.
  - Pulses may wrap across the period boundary, but on-time per period is unchanged.
  - The active-register swap still happens only at `pcnt` wrap, so a staggered channel may finish one period on the old duty.
- `PWM_STAGGER_EN` undefined: all channels are aligned to `pcnt`==0.

## Structure
- Package `pwm_sched_pkg` contains:
  - the state enum `sched_state_t` {OFF, RUN};
  - function `clamp_duty(value, limit)`.
- Sub-module `pwm_channel_cmp` holds per-channel active/shadow registers, the optional phase offset and the registered compare. It is instantiated three times.
- The top level holds the FSM, both counters and the handshake.

## Test plan
Bench parameters: `PWM_INTERVAL`=12, `STEP_INTERVAL`=20.
- Reset, then `enable`=1 with duty 0/6/12 → red always 0, green high for 6 of every 12 cycles, blue constantly 1. `period_start` fires every 12 cycles.
- Load duty 3 at `pcnt`=5 → `duty_ready` is 0 until the wrap. The new width of 3 starts at the next `pcnt`=0, and the current period keeps its old width.
- Load a triple in the exact wrap cycle (`pcnt`=11) → it takes effect at the immediately following period, and `duty_ready` stays 1.
- Request duty 15 → clamped; the output is high for all 12 cycles.
- Drop `enable` mid-period, then raise it 4 cycles later → outputs are 0 the next cycle, `step_tick` is silent while off, and `pcnt` restarts at 0.
- With `PWM_STAGGER_EN`, duty 6 on all channels → green rises at `pcnt`=4 and blue at `pcnt`=8 (blue wraps). Each channel is high 6 cycles per period.
- Assert `rst` with `pending`=1 → all outputs 0 immediately, `duty_ready`=1, and the shadow value is never applied.
